cache_lru_age_n: RTL and testbench
==================================

Name: cache_lru_age_n

Overview:
- Parametrised true-LRU replacement controller for N-way set-associative caches. It is the successor to the fixed 4-way age-bit LRU used by the L1.
- Holds one age counter per way per set. Updates ages on every touch (hit or fill) and presents the victim way for a looked-up set.
- Adds a sequential init/flush sweep, so the age store needs no parallel reset and maps to flops or RAM.
- Sits beside the L1/L2 tag arrays. The cache controller drives touches and reads the victim on a miss.

Parameters:
- WAYS, 8, associativity; power of two, 2..16.
- SETS, 64, number of sets; power of two, >= 2.
- AW, $clog2(WAYS), way-index and age width (derived; do not override).
- IW, $clog2(SETS), set-index width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  request re-initialisation of all sets (single-cycle pulse).
- ready_o  out  1  high when the age store is initialised and accepting touches.
- touch_valid_i  in  1  commit a touch this cycle.
- touch_index_i  in  IW  set being touched.
- touch_way_i  in  AW  way being touched (becomes MRU).
- lookup_index_i  in  IW  set whose victim is requested.
- valid_mask_i  in  WAYS  line-valid bits of the lookup set (used only with the optional feature).
- victim_way_o  out  AW  way to replace in the lookup set.

Behaviour:
- Age encoding: 0 = LRU, WAYS-1 = MRU. Within every set the ages are always a permutation of 0..WAYS-1.
- Touch of way w with old age a, when touch_valid_i && ready_o:
  - age[w] <= WAYS-1.
  - Every way with age > a decrements by 1.
  - Ways with age < a are unchanged.
  - If a == WAYS-1, nothing changes.
  - Write takes effect at the next rising edge.
- Victim: combinational from the registered ages of lookup_index_i. It is the way whose age == 0.
- Same-cycle touch and lookup on the same set: victim_way_o reflects the pre-touch ages (no bypass). The updated victim appears the following cycle.
- FSM states are INIT and READY.
- Reset (asserts asynchronously, any state):
  - State -> INIT, init counter -> 0, ready_o = 0.
  - victim_way_o is don't-care while ready_o = 0; the bench must not check it.
  - The age store itself is not reset.
- INIT:
  - Each cycle, write age[k] = k for every way k of set init_cnt, then init_cnt += 1.
  - After the write of set SETS-1, go to READY. ready_o rises exactly SETS cycles after reset deasserts.
  - Touches are ignored in INIT.
  - flush_i in INIT restarts the counter at 0.
- READY:
  - ready_o = 1 and touches are applied.
  - flush_i -> INIT with counter 0. A touch in the same cycle as flush_i is dropped (flush wins).
- The init counter is IW+1 bits wide so that the terminal count does not wrap.

Optional Feature:
- Macro LRU_INVALID_FIRST_EN.
- Defined: if valid_mask_i != all-ones, victim_way_o = lowest-index way with valid_mask_i bit = 0. Otherwise the age-0 way is the victim.
- Undefined: valid_mask_i is ignored and the victim is always the age-0 way.
- Touch/age update behaviour is identical in both builds.

Decomposition:
- cache_def package gains:
  - LRU_WAYS_L1 / LRU_SETS_L1 and the L2 equivalents.
  - A typedef for the per-set age vector (WAYS x AW).
  - An enum lru_state_e {LRU_INIT, LRU_READY}.
- One combinational sub-module, lru_age_update: takes a set's age vector and a touched way, and returns the next age vector. It is instantiated once on the touch path.

Test Plan (WAYS=8, SETS=16, macro undefined unless stated):
1. Release reset at t0 -> ready_o = 0 for 16 cycles and 1 at cycle 16. Lookup of every set then gives victim 0.
2. Set 5: touch ways 0,1,...,7 in order -> victim 0. Touch 0 -> victim 1. Set 6 victim still 0.
3. Set 2: touch way 3 twice back-to-back -> second touch leaves the ages unchanged, victim 0. The ages remain a permutation every cycle (scoreboard model).
4. Same cycle: touch set 3 way 0 and lookup set 3 -> victim 0 that cycle, victim 1 the next cycle.
5. Flush and reset mid-operation:
   - flush_i with a concurrent touch in READY -> touch dropped, ready_o low for 16 cycles, all victims 0 afterwards.
   - rst_i pulsed at INIT cycle 7 -> sweep restarts and ready_o rises 16 cycles after rst_i deasserts.
6. Macro defined, set 4 after touching 0..7, valid_mask_i = 8'b1111_1011 -> victim 2. valid_mask_i = 8'hFF -> victim 0. Same stimulus with the macro undefined -> victim 0 in both cases.

Source files
------------

// File: rtl/cache_def.sv
// Shared cache definitions: LRU geometry for L1/L2, per-set age vectors and LRU FSM states.
package cache_def;

   localparam int unsigned LRU_WAYS_L1 = 8;
   localparam int unsigned LRU_SETS_L1 = 64;
   localparam int unsigned LRU_WAYS_L2 = 16;
   localparam int unsigned LRU_SETS_L2 = 1024;

   typedef logic [LRU_WAYS_L1-1:0][$clog2(LRU_WAYS_L1)-1:0] lru_age_l1_t;
   typedef logic [LRU_WAYS_L2-1:0][$clog2(LRU_WAYS_L2)-1:0] lru_age_l2_t;

   typedef enum logic {
      LRU_INIT,
      LRU_READY
   } lru_state_e;

endpackage

// File: rtl/lru_age_update.sv
// Next-state ages for one set: touched way becomes MRU, younger ways shift down by one.
module lru_age_update #(
   parameter int unsigned WAYS = 8,
   parameter int unsigned AW   = $clog2(WAYS)
) (
   input  logic [WAYS-1:0][AW-1:0] age_i,
   input  logic [AW-1:0]           way_i,
   output logic [WAYS-1:0][AW-1:0] age_o
);

   logic [AW-1:0] old_age;

   always_comb begin
      age_o   = age_i;
      old_age = age_i[way_i];
      for (int unsigned k = 0; k < WAYS; k++) begin
         if (AW'(k) == way_i) begin
            age_o[k] = '1;
         end else if (age_i[k] > old_age) begin
            age_o[k] = age_i[k] - AW'(1);
         end
      end
   end

endmodule

// File: rtl/cache_lru_age_n.sv
// N-way true-LRU age store with sequential init/flush sweep.
// Optional macro LRU_INVALID_FIRST_EN: prefer the lowest invalid way as victim.
module cache_lru_age_n
   import cache_def::*;
#(
   parameter int unsigned WAYS = LRU_WAYS_L1,
   parameter int unsigned SETS = LRU_SETS_L1,
   parameter int unsigned AW   = $clog2(WAYS),
   parameter int unsigned IW   = $clog2(SETS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   output logic            ready_o,
   input  logic            touch_valid_i,
   input  logic [IW-1:0]   touch_index_i,
   input  logic [AW-1:0]   touch_way_i,
   input  logic [IW-1:0]   lookup_index_i,
   input  logic [WAYS-1:0] valid_mask_i,
   output logic [AW-1:0]   victim_way_o
);

   typedef logic [WAYS-1:0][AW-1:0] age_vec_t;

   age_vec_t   age_mem [SETS];
   age_vec_t   touch_age, touch_next, init_age, lookup_age;
   lru_state_e state_q, state_d;
   logic [IW:0] cnt_q, cnt_d;
   logic        touch_en;

   assign ready_o    = (state_q == LRU_READY);
   assign touch_en   = touch_valid_i && ready_o && !flush_i;
   assign touch_age  = age_mem[touch_index_i];
   assign lookup_age = age_mem[lookup_index_i];

   always_comb begin
      init_age = '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
         init_age[k] = AW'(k);
      end
   end

   lru_age_update #(
      .WAYS (WAYS),
      .AW   (AW)
   ) u_age_update (
      .age_i (touch_age),
      .way_i (touch_way_i),
      .age_o (touch_next)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = LRU_INIT;
         cnt_d   = '0;
      end else if (state_q == LRU_INIT) begin
         cnt_d = cnt_q + (IW+1)'(1);
         if (cnt_q == (IW+1)'(SETS-1)) begin
            state_d = LRU_READY;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= LRU_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Age store has no reset; the INIT sweep rewrites every set instead.
   always_ff @(posedge clk_i) begin
      if (state_q == LRU_INIT) begin
         age_mem[cnt_q[IW-1:0]] <= init_age;
      end else if (touch_en) begin
         age_mem[touch_index_i] <= touch_next;
      end
   end

   always_comb begin
      victim_way_o = '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
         if (lookup_age[k] == '0) begin
            victim_way_o = AW'(k);
         end
      end
`ifdef LRU_INVALID_FIRST_EN
      if (valid_mask_i != '1) begin
         for (int unsigned k = WAYS; k > 0; k--) begin
            if (!valid_mask_i[k-1]) begin
               victim_way_o = AW'(k-1);
            end
         end
      end
`endif
   end

`ifndef LRU_INVALID_FIRST_EN
   logic unused_mask;
   assign unused_mask = ^valid_mask_i;
`endif

endmodule

// File: tb/tb_cache_lru_age_n.sv
// Directed self-checking bench for cache_lru_age_n (WAYS=8, SETS=16).
module tb_cache_lru_age_n;

   localparam int unsigned WAYS = 8;
   localparam int unsigned SETS = 16;
   localparam int unsigned AW   = 3;
   localparam int unsigned IW   = 4;

`ifdef LRU_INVALID_FIRST_EN
   localparam int unsigned EXP_MASKED = 2;
`else
   localparam int unsigned EXP_MASKED = 0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic            ready_o;
   logic            touch_valid_i;
   logic [IW-1:0]   touch_index_i;
   logic [AW-1:0]   touch_way_i;
   logic [IW-1:0]   lookup_index_i;
   logic [WAYS-1:0] valid_mask_i;
   logic [AW-1:0]   victim_way_o;

   int n_assert = 0;
   int n_fail   = 0;
   int order [SETS][WAYS];

   cache_lru_age_n #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .ready_o        (ready_o),
      .touch_valid_i  (touch_valid_i),
      .touch_index_i  (touch_index_i),
      .touch_way_i    (touch_way_i),
      .lookup_index_i (lookup_index_i),
      .valid_mask_i   (valid_mask_i),
      .victim_way_o   (victim_way_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Recency list per set: order[s][0] is LRU, order[s][WAYS-1] is MRU.
   task automatic model_init();
      for (int s = 0; s < SETS; s++)
         for (int k = 0; k < WAYS; k++)
            order[s][k] = k;
   endtask

   task automatic model_touch(input int s, input int w);
      int p;
      p = 0;
      for (int k = 0; k < WAYS; k++)
         if (order[s][k] == w) p = k;
      for (int k = p; k < WAYS-1; k++)
         order[s][k] = order[s][k+1];
      order[s][WAYS-1] = w;
   endtask

   task automatic do_touch(input int s, input int w);
      touch_valid_i = 1'b1;
      touch_index_i = IW'(s);
      touch_way_i   = AW'(w);
      @(posedge clk_i);
      #1;
      touch_valid_i = 1'b0;
      model_touch(s, w);
   endtask

   task automatic look(input string tag, input int s, input int exp);
      lookup_index_i = IW'(s);
      #1;
      chk(tag, 32'(victim_way_o), exp);
   endtask

   task automatic check_ready_sweep(input string tag);
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk_i);
         #1;
         chk(tag, 32'(ready_o), (i == 16) ? 1 : 0);
      end
   endtask

   initial begin
      rst_i          = 1'b1;
      flush_i        = 1'b0;
      touch_valid_i  = 1'b0;
      touch_index_i  = '0;
      touch_way_i    = '0;
      lookup_index_i = '0;
      valid_mask_i   = '1;
      model_init();

      // 1: reset and init sweep
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_ready", 32'(ready_o), 0);
      rst_i = 1'b0;
      check_ready_sweep("init_ready");
      for (int s = 0; s < SETS; s++) look("init_victim", s, 0);

      // 2: set 5 full sweep of touches
      for (int w = 0; w < WAYS; w++) do_touch(5, w);
      look("s5_after_all", 5, 0);
      do_touch(5, 0);
      look("s5_after_t0", 5, 1);
      look("s6_untouched", 6, 0);

      // 3: repeated MRU touch, scoreboarded every cycle
      do_touch(2, 3);
      look("s2_t3_first", 2, order[2][0]);
      do_touch(2, 3);
      look("s2_t3_second", 2, 0);
      do_touch(2, 0);
      look("s2_t0", 2, order[2][0]);
      do_touch(2, 1);
      look("s2_t1", 2, 2);
      do_touch(2, 3);
      look("s2_t3_third", 2, order[2][0]);

      // 4: same-cycle touch and lookup see pre-touch ages
      touch_valid_i  = 1'b1;
      touch_index_i  = 4'd3;
      touch_way_i    = 3'd0;
      lookup_index_i = 4'd3;
      #1;
      chk("s3_same_cycle", 32'(victim_way_o), 0);
      @(posedge clk_i);
      #1;
      touch_valid_i = 1'b0;
      model_touch(3, 0);
      look("s3_next_cycle", 3, 1);

      // 5a: flush with concurrent touch; touch during INIT is ignored
      flush_i       = 1'b1;
      touch_valid_i = 1'b1;
      touch_index_i = 4'd5;
      touch_way_i   = 3'd1;
      @(posedge clk_i);
      #1;
      flush_i       = 1'b0;
      touch_valid_i = 1'b0;
      chk("flush_ready_low", 32'(ready_o), 0);
      for (int i = 1; i <= 16; i++) begin
         if (i == 3) begin
            touch_valid_i = 1'b1;
            touch_index_i = 4'd0;
            touch_way_i   = 3'd0;
         end
         @(posedge clk_i);
         #1;
         touch_valid_i = 1'b0;
         chk("flush_ready", 32'(ready_o), (i == 16) ? 1 : 0);
      end
      model_init();
      look("flush_s0", 0, 0);
      look("flush_s5", 5, 0);
      look("flush_s3", 3, 0);
      look("flush_s2", 2, 0);

      // 5b: asynchronous reset part-way through a flush sweep
      do_touch(5, 0);
      look("s5_pre_rst", 5, 1);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      repeat (7) @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_async_ready", 32'(ready_o), 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_ready_sweep("rst_ready");
      model_init();
      look("rst_s5", 5, 0);
      look("rst_s15", 15, 0);

      // 6: valid-mask victim selection
      for (int w = 0; w < WAYS; w++) do_touch(4, w);
      look("s4_all", 4, order[4][0]);
      valid_mask_i = 8'b1111_1011;
      look("s4_mask_hole", 4, EXP_MASKED);
      valid_mask_i = 8'hFF;
      look("s4_mask_full", 4, 0);
      do_touch(4, 0);
      look("s4_after_t0", 4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
